regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Sequencer and arbiter in front of the rename register file. Owns its write, tag-set (issue) and
//  tag-release (commit) ports. Arbitrates the single value-write port between RoB commit and a debug/CSR writer.
//  Sequences the mispredict flush as a 1-cycle clear followed by a drain stall.
//  All register-file-side outputs are registered. Issue/commit/debug ready signals are combinational.
// PARAMETERS
//  TAG_W        4  RoB tag width; zero-extended to 32b on rf_set_val_q_*
//  FLUSH_CYCLES 2  drain cycles after the rf_clear pulse (>=1)
//  STARVE_MAX   3  consecutive debug denials before debug wins the port for one cycle (>=1)
// PORTS
//  clk_in         in   1      system clock
//  rst_in         in   1      synchronous active-high reset
//  rdy_in         in   1      global ready; low = freeze
//  flush_req      in   1      mispredict flush request (RoB)
//  commit_valid   in   1      RoB head commit offered
//  commit_ready   out  1      commit accepted this cycle
//  commit_rd      in   5      destination reg
//  commit_val     in   32     result value
//  commit_tag     in   TAG_W  RoB tag of committing entry
//  issue_valid    in   1      issue rename request
//  issue_ready    out  1      rename accepted this cycle
//  issue_rd       in   5      destination reg being renamed
//  issue_tag      in   TAG_W  newly allocated RoB tag
//  dbg_valid      in   1      debug/CSR write request
//  dbg_ready      out  1      debug write accepted this cycle
//  dbg_rd         in   5      debug destination reg
//  dbg_val        in   32     debug write value
//  rf_set_reg     out  5      -> register file set_reg
//  rf_set_val     out  32     -> set_val
//  rf_set_reg_q_1 out  5      -> set_reg_q_1 (issue tag set)
//  rf_set_val_q_1 out  32     -> set_val_q_1
//  rf_set_reg_q_2 out  5      -> set_reg_q_2 (commit tag release)
//  rf_set_val_q_2 out  32     -> set_val_q_2
//  rf_clear       out  1      -> RoB_clear input of register file
//  busy           out  1      1 while state != RUN
// BEHAVIOUR
//  - Reset: all rf_* outputs 0, rf_clear 0, state RUN, starve_cnt 0. Readies are 0 while rst_in is high.
//  - States: RUN, CLEAR, DRAIN.
//    - RUN -> CLEAR on flush_req.
//    - CLEAR -> DRAIN after 1 cycle; drain_cnt loaded with FLUSH_CYCLES.
//    - DRAIN -> RUN when drain_cnt reaches 1; drain_cnt decrements each rdy_in cycle.
//    - flush_req in CLEAR or DRAIN reloads drain_cnt and stays in or enters DRAIN.
//  - rf_clear = 1 exactly for the cycle in CLEAR. All other rf_* outputs are 0 in CLEAR and DRAIN.
//  - go = rdy_in & !rst_in & state==RUN & !flush_req.
//    - Requests presented in the flush_req cycle are dropped, not accepted.
//    - dbg_win = dbg_valid & (!commit_valid | starve_cnt==STARVE_MAX).
//    - issue_ready = go.
//    - dbg_ready = go & dbg_win.
//    - commit_ready = go & !dbg_win.
//  - Latency 1 for all accepted requests; outputs are updated on the next rising edge.
//    - Commit: rf_set_reg=commit_rd, rf_set_val=commit_val, rf_set_reg_q_2=commit_rd, rf_set_val_q_2=zext(commit_tag).
//    - Debug: rf_set_reg=dbg_rd, rf_set_val=dbg_val, rf_set_reg_q_2=0.
//    - Issue: rf_set_reg_q_1=issue_rd, rf_set_val_q_1=zext(issue_tag). Independent of commit/debug in the same cycle.
//    - No accepted request on a port drives that port's reg and value outputs to 0 (no-op).
//  - rd==0 on any source: handshake completes normally, but the corresponding reg and value outputs are driven 0.
//  - Same-register issue and commit in one cycle: both are forwarded unchanged. The register file already keeps the new tag busy.
//  - starve_cnt:
//    - +1 (saturating at STARVE_MAX) each cycle with dbg_valid & go & !dbg_ready.
//    - Cleared on dbg_ready, on flush_req and in CLEAR.
//  - rdy_in low: no handshake accepted, rf_* outputs driven 0 next edge, state and counters hold.
//  - Reset mid-flush: returns to RUN; rf_clear is 0 the next cycle.
// TESTING
//  1. Reset, then commit rd=5 val=0xDEADBEEF tag=3 -> next cycle rf_set_reg=5, rf_set_val=0xDEADBEEF, rf_set_reg_q_2=5, rf_set_val_q_2=3.
//  2. Issue rd=7 tag=9 with commit rd=7 tag=2 in the same cycle -> both accepted; next cycle q_1=(7,9) and q_2=(7,2).
//  3. commit_valid held high, dbg_valid rd=1 val=0x55 -> debug denied 3 cycles, granted on cycle 4 (commit_ready=0 that cycle), rf_set_reg=1.
//  4. flush_req for 1 cycle with commit_valid high -> commit not accepted; rf_clear=1 for one cycle; readies low for 2 more cycles; busy=1 for 3 cycles.
//  5. Second flush_req during DRAIN -> drain restarts; exactly 2 cycles of DRAIN after the second request; rf_clear is not re-pulsed.
//  6. Commit rd=0, and commit with rdy_in=0 -> first: handshake completes, rf_set_reg=0; second: commit_ready=0, outputs 0.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Port sequencer/arbiter in front of the rename register file: issue tag-set, commit/debug value write, flush clear.
// Latency: 1 cycle from accepted handshake to registered rf_* outputs; rf_clear pulses one cycle after flush_req.
// Backpressure: readies are combinational; all drop while rdy_in is low, in reset, during a flush, or in a flush_req cycle.
module regfile_port_ctrl #(
    parameter int TAG_W        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int STARVE_MAX   = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_req,
    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic [4:0]       commit_rd,
    input  logic [31:0]      commit_val,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             dbg_valid,
    output logic             dbg_ready,
    input  logic [4:0]       dbg_rd,
    input  logic [31:0]      dbg_val,
    output logic [4:0]       rf_set_reg,
    output logic [31:0]      rf_set_val,
    output logic [4:0]       rf_set_reg_q_1,
    output logic [31:0]      rf_set_val_q_1,
    output logic [4:0]       rf_set_reg_q_2,
    output logic [31:0]      rf_set_val_q_2,
    output logic             rf_clear,
    output logic             busy
);

    localparam int DW = $clog2(FLUSH_CYCLES + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;

    logic go;
    logic dbg_win;
    logic commit_acc;
    logic dbg_acc;
    logic issue_acc;

    assign go           = rdy_in && !rst_in && (state == ST_RUN) && !flush_req;
    assign dbg_win      = dbg_valid && (!commit_valid || (starve_cnt == SW'(STARVE_MAX)));
    assign issue_ready  = go;
    assign dbg_ready    = go && dbg_win;
    assign commit_ready = go && !dbg_win;
    assign commit_acc   = commit_valid && commit_ready;
    assign dbg_acc      = dbg_valid && dbg_ready;
    assign issue_acc    = issue_valid && issue_ready;
    assign busy         = (state != ST_RUN);

    // State, drain counter and debug starvation counter registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_RUN;
            drain_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Flush sequencing and starvation bookkeeping; the CLEAR cycle always advances so the clear stays a single pulse
    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        starve_nxt = starve_cnt;
        case (state)
            ST_RUN: begin
                if (rdy_in && flush_req) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = ST_DRAIN;
                drain_nxt = DW'(FLUSH_CYCLES);
            end
            ST_DRAIN: begin
                if (rdy_in) begin
                    if (flush_req)                 drain_nxt = DW'(FLUSH_CYCLES);
                    else if (drain_cnt == DW'(1))  state_nxt = ST_RUN;
                    else                           drain_nxt = drain_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        if (state == ST_CLEAR) begin
            starve_nxt = '0;
        end else if (rdy_in) begin
            if (flush_req || dbg_ready)
                starve_nxt = '0;
            else if (dbg_valid && go && (starve_cnt != SW'(STARVE_MAX)))
                starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Registered register-file ports; anything not accepted this cycle (or targeting r0) becomes a zero no-op
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rf_set_reg     <= '0;
            rf_set_val     <= '0;
            rf_set_reg_q_1 <= '0;
            rf_set_val_q_1 <= '0;
            rf_set_reg_q_2 <= '0;
            rf_set_val_q_2 <= '0;
            rf_clear       <= 1'b0;
        end else begin
            rf_set_reg     <= '0;
            rf_set_val     <= '0;
            rf_set_reg_q_1 <= '0;
            rf_set_val_q_1 <= '0;
            rf_set_reg_q_2 <= '0;
            rf_set_val_q_2 <= '0;
            if (commit_acc && (commit_rd != 5'd0)) begin
                rf_set_reg     <= commit_rd;
                rf_set_val     <= commit_val;
                rf_set_reg_q_2 <= commit_rd;
                rf_set_val_q_2 <= {{(32-TAG_W){1'b0}}, commit_tag};
            end else if (dbg_acc && (dbg_rd != 5'd0)) begin
                rf_set_reg <= dbg_rd;
                rf_set_val <= dbg_val;
            end
            if (issue_acc && (issue_rd != 5'd0)) begin
                rf_set_reg_q_1 <= issue_rd;
                rf_set_val_q_1 <= {{(32-TAG_W){1'b0}}, issue_tag};
            end
            rf_clear <= (state == ST_RUN) && rdy_in && flush_req;
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: directed scenarios then random traffic against a cycle-level reference model.
// Expected readies/outputs are queued with a cycle stamp and checked by an independent monitor.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_regfile_port_ctrl;

    localparam int TAG_W        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int STARVE_MAX   = 3;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, flush_req;
    logic             commit_valid, commit_ready;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_val;
    logic [TAG_W-1:0] commit_tag;
    logic             issue_valid, issue_ready;
    logic [4:0]       issue_rd;
    logic [TAG_W-1:0] issue_tag;
    logic             dbg_valid, dbg_ready;
    logic [4:0]       dbg_rd;
    logic [31:0]      dbg_val;
    logic [4:0]       rf_set_reg, rf_set_reg_q_1, rf_set_reg_q_2;
    logic [31:0]      rf_set_val, rf_set_val_q_1, rf_set_val_q_2;
    logic             rf_clear, busy;

    regfile_port_ctrl #(.TAG_W(TAG_W), .FLUSH_CYCLES(FLUSH_CYCLES), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_req(flush_req),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_tag(commit_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_val(dbg_val),
        .rf_set_reg(rf_set_reg), .rf_set_val(rf_set_val),
        .rf_set_reg_q_1(rf_set_reg_q_1), .rf_set_val_q_1(rf_set_val_q_1),
        .rf_set_reg_q_2(rf_set_reg_q_2), .rf_set_val_q_2(rf_set_val_q_2),
        .rf_clear(rf_clear), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic cr, ir, dr, bz;
    } rdy_exp_t;

    typedef struct {
        int          cyc;
        logic [4:0]  r0, r1, r2;
        logic [31:0] v0, v1, v2;
        logic        clr;
    } out_exp_t;

    rdy_exp_t rq[$];
    out_exp_t oq[$];

    // Reference model state: remaining non-running cycles (FLUSH_CYCLES+1 means the clear cycle) and debug denials
    int m_busy   = 0;
    int m_starve = 0;

    logic s_cr, s_ir, s_dr, s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_eval();
        rdy_exp_t r;
        out_exp_t o;
        logic running, clearing, go_m, win;
        running  = (m_busy == 0);
        clearing = (m_busy == FLUSH_CYCLES + 1);
        go_m     = !rst_in && rdy_in && running && !flush_req;
        win      = dbg_valid && (!commit_valid || (m_starve == STARVE_MAX));
        r.cyc = cyc;
        r.bz  = !running;
        r.ir  = go_m;
        r.dr  = go_m && win;
        r.cr  = go_m && !win;
        o.cyc = cyc + 1;
        o.r0 = '0; o.v0 = '0; o.r1 = '0; o.v1 = '0; o.r2 = '0; o.v2 = '0;
        if (commit_valid && r.cr && commit_rd != 5'd0) begin
            o.r0 = commit_rd; o.v0 = commit_val;
            o.r2 = commit_rd; o.v2 = 32'(commit_tag);
        end else if (dbg_valid && r.dr && dbg_rd != 5'd0) begin
            o.r0 = dbg_rd; o.v0 = dbg_val;
        end
        if (issue_valid && r.ir && issue_rd != 5'd0) begin
            o.r1 = issue_rd; o.v1 = 32'(issue_tag);
        end
        o.clr = !rst_in && rdy_in && running && flush_req;
        if (rst_in) begin
            m_busy   = 0;
            m_starve = 0;
        end else begin
            if (clearing) m_starve = 0;
            else if (rdy_in) begin
                if (flush_req || r.dr) m_starve = 0;
                else if (dbg_valid && go_m) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            end
            if (running) begin
                if (rdy_in && flush_req) m_busy = FLUSH_CYCLES + 1;
            end else if (clearing) begin
                m_busy = FLUSH_CYCLES;
            end else if (rdy_in) begin
                m_busy = flush_req ? FLUSH_CYCLES : m_busy - 1;
            end
        end
        rq.push_back(r);
        oq.push_back(o);
    endtask

    // One clock of stimulus: predict, snapshot combinational readies, advance to just after the next edge
    task automatic step();
        model_eval();
        #2;
        s_cr = commit_ready; s_ir = issue_ready; s_dr = dbg_ready; s_busy = busy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        flush_req = 0; commit_valid = 0; issue_valid = 0; dbg_valid = 0;
        commit_rd = '0; commit_val = '0; commit_tag = '0;
        issue_rd = '0; issue_tag = '0; dbg_rd = '0; dbg_val = '0;
    endtask

    // Monitor: compare every DUT presentation against the queued expectation due this cycle
    rdy_exp_t me_r;
    out_exp_t me_o;
    always @(negedge clk_in) begin
        while (rq.size() > 0 && rq[0].cyc <= cyc) begin
            me_r = rq.pop_front();
            chk("commit_ready", 32'(commit_ready), 32'(me_r.cr));
            chk("issue_ready", 32'(issue_ready), 32'(me_r.ir));
            chk("dbg_ready", 32'(dbg_ready), 32'(me_r.dr));
            chk("busy", 32'(busy), 32'(me_r.bz));
        end
        while (oq.size() > 0 && oq[0].cyc <= cyc) begin
            me_o = oq.pop_front();
            chk("rf_set_reg", 32'(rf_set_reg), 32'(me_o.r0));
            chk("rf_set_val", rf_set_val, me_o.v0);
            chk("rf_set_reg_q_1", 32'(rf_set_reg_q_1), 32'(me_o.r1));
            chk("rf_set_val_q_1", rf_set_val_q_1, me_o.v1);
            chk("rf_set_reg_q_2", 32'(rf_set_reg_q_2), 32'(me_o.r2));
            chk("rf_set_val_q_2", rf_set_val_q_2, me_o.v2);
            chk("rf_clear", 32'(rf_clear), 32'(me_o.clr));
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n_busy, n_low, n_clr;
        rst_in = 1; rdy_in = 1;
        idle_inputs();
        @(posedge clk_in); #1;
        repeat (3) step();
        rst_in = 0;
        chk("reset_rf_set_reg", 32'(rf_set_reg), 32'd0);
        chk("reset_rf_clear", 32'(rf_clear), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // 1: plain commit
        commit_valid = 1; commit_rd = 5'd5; commit_val = 32'hDEADBEEF; commit_tag = 4'd3;
        step();
        idle_inputs();
        chk("t1_ready", 32'(s_cr), 32'd1);
        chk("t1_reg", 32'(rf_set_reg), 32'd5);
        chk("t1_val", rf_set_val, 32'hDEADBEEF);
        chk("t1_reg_q2", 32'(rf_set_reg_q_2), 32'd5);
        chk("t1_val_q2", rf_set_val_q_2, 32'd3);

        // 2: issue and commit to the same register
        issue_valid = 1; issue_rd = 5'd7; issue_tag = 4'd9;
        commit_valid = 1; commit_rd = 5'd7; commit_val = 32'h1234; commit_tag = 4'd2;
        step();
        idle_inputs();
        chk("t2_both_ready", 32'({s_cr, s_ir}), 32'd3);
        chk("t2_q1", {rf_set_reg_q_1, rf_set_val_q_1[26:0]}, {5'd7, 27'd9});
        chk("t2_q2", {rf_set_reg_q_2, rf_set_val_q_2[26:0]}, {5'd7, 27'd2});

        // 3: debug starvation under continuous commit traffic
        commit_valid = 1; commit_rd = 5'd2; commit_val = 32'hAAAA; commit_tag = 4'd1;
        dbg_valid = 1; dbg_rd = 5'd1; dbg_val = 32'h55;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t3_dbg_ready_%0d", i), 32'(s_dr), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t3_commit_denied", 32'(s_cr), 32'd0);
        chk("t3_reg", 32'(rf_set_reg), 32'd1);
        chk("t3_val", rf_set_val, 32'h55);
        idle_inputs();

        // 4: flush with a commit offered
        commit_valid = 1; commit_rd = 5'd6; commit_val = 32'h66; commit_tag = 4'd4;
        flush_req = 1;
        step();
        flush_req = 0;
        chk("t4_commit_in_flush", 32'(s_cr), 32'd0);
        chk("t4_clear_pulse", 32'(rf_clear), 32'd1);
        n_busy = 0; n_low = 0; n_clr = 0;
        repeat (6) begin
            step();
            n_busy += int'(s_busy); n_low += int'(!s_cr); n_clr += int'(rf_clear);
        end
        chk("t4_busy_cycles", 32'(n_busy), 32'd3);
        chk("t4_ready_low_cycles", 32'(n_low), 32'd3);
        chk("t4_single_clear", 32'(n_clr), 32'd0);
        idle_inputs();

        // 5: second flush during drain restarts the drain without a new clear
        flush_req = 1; step();
        flush_req = 0; step(); step();
        flush_req = 1; step();
        flush_req = 0;
        n_busy = 0; n_clr = int'(rf_clear);
        repeat (6) begin
            step();
            n_busy += int'(s_busy); n_clr += int'(rf_clear);
        end
        chk("t5_drain_cycles", 32'(n_busy), 32'd2);
        chk("t5_no_reclear", 32'(n_clr), 32'd0);

        // 6: commit to r0, then commit while frozen
        commit_valid = 1; commit_rd = 5'd0; commit_val = 32'h123; commit_tag = 4'd5;
        step();
        chk("t6_r0_ready", 32'(s_cr), 32'd1);
        chk("t6_r0_reg", 32'(rf_set_reg), 32'd0);
        chk("t6_r0_val", rf_set_val, 32'd0);
        chk("t6_r0_val_q2", rf_set_val_q_2, 32'd0);
        rdy_in = 0; commit_rd = 5'd4;
        step();
        chk("t6_frozen_ready", 32'(s_cr), 32'd0);
        chk("t6_frozen_reg", 32'(rf_set_reg), 32'd0);
        rdy_in = 1;
        idle_inputs();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rst_in       = ($urandom_range(63) == 0);
            rdy_in       = ($urandom_range(7) != 0);
            flush_req    = ($urandom_range(15) == 0);
            commit_valid = ($urandom_range(2) != 0);
            commit_rd    = 5'($urandom_range(31));
            commit_val   = $urandom;
            commit_tag   = 4'($urandom_range(15));
            issue_valid  = ($urandom_range(1) != 0);
            issue_rd     = 5'($urandom_range(31));
            issue_tag    = 4'($urandom_range(15));
            dbg_valid    = ($urandom_range(1) != 0);
            dbg_rd       = 5'($urandom_range(31));
            dbg_val      = $urandom;
            step();
        end
        rst_in = 0; rdy_in = 1;
        idle_inputs();
        repeat (4) step();
        @(negedge clk_in); #1;
        chk("scoreboard_drained", 32'(rq.size() + oq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
